t09_lfsr_rng: RTL and testbench

- Parametrised successor to the team's 16-bit free-running counter RNG.
- A Galois LFSR provides a maximal-length pseudo-random sequence. It supports freeze (hold), runtime reseeding and zero-lockup protection.
- A req/valid draw engine returns uniformly distributed values in [0, limit) using bounded rejection sampling.
- Used by game/display logic (colour cycling, spawn positions) that needs range-limited randoms rather than raw counts.

---
 rtl/t09_rng_pkg.sv | 35 +++
 rtl/t09_lfsr_core.sv | 39 +++
 rtl/t09_lfsr_rng.sv | 114 +++++++++++
 tb/tb_t09_lfsr_rng.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t09_rng_pkg.sv
// Shared types and helpers for the range-limited LFSR random generator.
// Polynomial defaults exist only for 8, 16 and 32 bits; other widths must pass POLY explicitly.
package t09_rng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } draw_state_t;

    localparam logic [7:0]  POLY_W8  = 8'hB8;
    localparam logic [15:0] POLY_W16 = 16'hB400;
    localparam logic [31:0] POLY_W32 = 32'h80200003;

    function automatic logic [31:0] default_poly(input int width);
        case (width)
            8:       return 32'(POLY_W8);
            32:      return POLY_W32;
            default: return 32'(POLY_W16);
        endcase
    endfunction

    // Smallest 2^k-1 covering lim-1; a zero limit means the full range.
    function automatic logic [31:0] mask_from_limit(input logic [31:0] lim);
        logic [31:0] v;
        if (lim == '0) return '1;
        v = lim - 32'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        v = v | (v >> 16);
        return v;
    endfunction

endpackage

// File: rtl/t09_lfsr_core.sv
// Galois LFSR register with seed loading, freeze and zero-lockup recovery.
module t09_lfsr_core
    import t09_rng_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] raw
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_val;
    logic [WIDTH-1:0] step_val;

    assign seed_val = (seed == '0) ? SEED : seed;
    assign step_val = state[0] ? ((state >> 1) ^ POLY) : (state >> 1);

    // The zero guard outranks freeze so a corrupted state can never stick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else if (seed_load) begin
            state <= seed_val;
        end else if (state == '0) begin
            state <= SEED;
        end else if (!freeze) begin
            state <= step_val;
        end
    end

    assign raw = state;

endmodule

// File: rtl/t09_lfsr_rng.sv
// LFSR random source with a req/valid engine returning uniform values in [0, limit).
//   state | meaning
//   IDLE  | waiting for req; limit and mask are latched on acceptance
//   DRAW  | one rejection-sampling attempt per unfrozen edge until accept
module t09_lfsr_rng
    import t09_rng_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_out,
    output logic [WIDTH-1:0] raw
);

    localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    draw_state_t      state;
    draw_state_t      state_n;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] mask_q;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_n;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] acc_val;
    logic             start;
    logic             accept;

    t09_lfsr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .seed_load (seed_load),
        .seed      (seed),
        .raw       (raw)
    );

    assign cand = raw & mask_q;

    always_comb begin
        state_n = state;
        tries_n = tries;
        start   = 1'b0;
        accept  = 1'b0;
        acc_val = cand;
        case (state)
            IDLE: begin
                if (req && !seed_load) begin
                    start   = 1'b1;
                    tries_n = '0;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                if (seed_load) begin
                    state_n = IDLE;
                end else if (!freeze) begin
                    if (limit_q == '0) begin
                        accept  = 1'b1;
                        acc_val = raw;
                    end else if (cand < limit_q) begin
                        accept = 1'b1;
                    end else if (tries == LAST_TRY) begin
                        // mask_q < 2*limit_q, so the folded value is in range
                        accept  = 1'b1;
                        acc_val = cand - limit_q;
                    end else begin
                        tries_n = tries + 1'b1;
                    end
                    if (accept) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tries      <= '0;
            limit_q    <= '0;
            mask_q     <= '0;
            rand_out   <= '0;
            rand_valid <= 1'b0;
        end else begin
            state      <= state_n;
            tries      <= tries_n;
            rand_valid <= accept;
            if (start) begin
                limit_q <= limit;
                mask_q  <= WIDTH'(mask_from_limit(32'(limit)));
            end
            if (accept) rand_out <= acc_val;
        end
    end

    assign busy = (state == DRAW);

endmodule

// File: tb/tb_t09_lfsr_rng.sv
// Randomized bench for t09_lfsr_rng: LFSR sequence/period, seeding, ranged draws and mid-draw events.
module tb_t09_lfsr_rng;

    localparam logic [15:0] POLY      = 16'hB400;
    localparam int          MAX_TRIES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic        seed_load;
    logic [15:0] seed;
    logic        req;
    logic [15:0] limit;
    logic        busy;
    logic        rand_valid;
    logic [15:0] rand_out;
    logic [15:0] raw;

    logic [15:0] ref_lfsr;
    logic [15:0] last_out;
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    int          seen[10];
    logic [15:0] seq_tbl[13] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40,
                                 16'h05A0, 16'h02D0, 16'h0168, 16'h00B4, 16'h005A, 16'h002D,
                                 16'hB416};
    logic [15:0] lims[9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd16, 16'd17,
                             16'h8000, 16'h8001, 16'hFFFF};

    t09_lfsr_rng #(
        .WIDTH     (16),
        .POLY      (POLY),
        .SEED      (16'h0001),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .freeze     (freeze),
        .seed_load  (seed_load),
        .seed       (seed),
        .req        (req),
        .limit      (limit),
        .busy       (busy),
        .rand_valid (rand_valid),
        .rand_out   (rand_out),
        .raw        (raw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Reference LFSR from the seed/freeze/step rules.
    always @(posedge clk or negedge reset) begin
        if (!reset)          ref_lfsr <= 16'h0001;
        else if (seed_load)  ref_lfsr <= (seed == 16'h0) ? 16'h0001 : seed;
        else if (!freeze)    ref_lfsr <= nxt(ref_lfsr);
    end

    always @(negedge clk) begin
        if (mon_en && reset) chk("raw_model", raw, ref_lfsr);
    end

    // Expected draw result from the state at the request, and the negedge count to the pulse.
    task automatic draw_model(input logic [15:0] s0, input logic [15:0] lim,
                              output logic [15:0] val, output int edges);
        logic [15:0] s;
        int m;
        int c;
        s = s0;
        m = 0;
        if (lim == 16'h0) m = 'hFFFF;
        else while (m < int'(lim) - 1) m = m * 2 + 1;
        val   = 16'h0;
        edges = 0;
        for (int t = 0; t < MAX_TRIES; t++) begin
            s = nxt(s);
            c = int'(s) & m;
            if (lim == 16'h0) begin
                val = s; edges = t + 2; break;
            end
            if (c < int'(lim)) begin
                val = 16'(c); edges = t + 2; break;
            end
            if (t == MAX_TRIES - 1) begin
                val = 16'(c - int'(lim)); edges = t + 2;
            end
        end
    endtask

    task automatic draw(input logic [15:0] lim, input int frz);
        logic [15:0] ev;
        int ee;
        int n;
        bit got;
        draw_model(ref_lfsr, lim, ev, ee);
        req   = 1'b1;
        limit = lim;
        @(negedge clk);
        req   = 1'b0;
        limit = 16'($urandom);
        chk("draw_busy", busy, 1);
        chk("draw_vld_lo", rand_valid, 0);
        if (frz > 0) begin
            freeze = 1'b1;
            repeat (frz) begin
                @(negedge clk);
                chk("frz_busy", busy, 1);
                chk("frz_vld_lo", rand_valid, 0);
            end
            freeze = 1'b0;
            ee += frz;
        end
        n   = 1 + frz;
        got = 1'b0;
        while (!got && n < ee + 4) begin
            @(negedge clk);
            n++;
            if (rand_valid) got = 1'b1;
        end
        chk("latency", n, ee);
        chk("lat_bound", (n - frz) <= MAX_TRIES + 1, 1);
        chk("value", rand_out, ev);
        if (lim != 16'h0) chk("in_range", rand_out < lim, 1);
        last_out = ev;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zero;
        int per;
        int v;
        reset = 1'b1; freeze = 1'b0; seed_load = 1'b0; seed = 16'h0; req = 1'b0; limit = 16'h0;
        last_out = 16'h0;
        foreach (seen[i]) seen[i] = 0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_raw", raw, 16'h0001);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rand_valid, 0);
        chk("rst_out", rand_out, 0);

        reset  = 1'b1;
        mon_en = 1'b1;
        zero = 0;
        per  = 0;
        for (int i = 1; i <= 70000; i++) begin
            @(negedge clk);
            if (i < 13) chk("seq", raw, seq_tbl[i]);
            if (raw == 16'h0) zero++;
            if (raw == 16'h0001) begin
                per = i;
                break;
            end
        end
        chk("period", per, 65535);
        chk("never_zero", zero, 0);

        seed_load = 1'b1; seed = 16'h0;
        @(negedge clk);
        chk("seed_zero", raw, 16'h0001);
        seed = 16'hACE1; freeze = 1'b1;
        @(negedge clk);
        chk("seed_frz", raw, 16'hACE1);
        seed_load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("frz_hold", raw, 16'hACE1);
        end
        freeze = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            draw(16'd10, 0);
            v = int'(rand_out);
            if (v < 10) seen[v]++;
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("pulse_lo", rand_valid, 0);
            end
        end
        for (int d = 0; d < 10; d++) chk("hist_hit", seen[d] > 0, 1);

        foreach (lims[i]) draw(lims[i], 0);
        repeat (40) draw(16'($urandom), 0);

        draw(16'd10, 5);
        repeat (4) draw(16'($urandom_range(0, 300)), int'($urandom_range(1, 6)));

        req = 1'b1; limit = 16'd1000;
        @(negedge clk);
        req = 1'b0;
        chk("abort_busy_pre", busy, 1);
        seed_load = 1'b1; seed = 16'($urandom);
        @(negedge clk);
        seed_load = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", rand_valid, 0);
        chk("abort_out", rand_out, last_out);
        @(negedge clk);
        chk("abort_valid2", rand_valid, 0);

        draw(16'd7, 0);
        req = 1'b1; limit = 16'd1000;
        @(negedge clk);
        req = 1'b0;
        chk("rmid_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", rand_valid, 0);
        chk("arst_out", rand_out, 0);
        chk("arst_raw", raw, 16'h0001);
        @(negedge clk);
        reset    = 1'b1;
        last_out = 16'h0;
        @(negedge clk);
        draw(16'd10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
